// File: rtl/arbitro_funcoes.sv
// rtl/arbitro_funcoes.sv - timed-ownership arbiter sharing FUN0..FUN2 between stations IE01 and IE02
//
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_req_ie0x                   request level per station; a rising edge is a new request
//   i_fun_ie0x [2:0]             requested function, one-hot
//   i_perf_ie0x [1:0]            profile level, 0 = no valid profile
//   o_gnt_ie0x                   station owns its captured function
//   o_wait_ie0x                  station is blocked by the other station
//   o_fun_ativa [2:0]            OR of the functions currently owned
//   o_perf_dono [1:0]            profile of the most recent grant
//   o_err                        one-cycle pulse on a rejected request
module arbitro_funcoes #(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int CNT_W       = 26
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_req_ie01,
    input  logic       i_req_ie02,
    input  logic [2:0] i_fun_ie01,
    input  logic [2:0] i_fun_ie02,
    input  logic [1:0] i_perf_ie01,
    input  logic [1:0] i_perf_ie02,
    output logic       o_gnt_ie01,
    output logic       o_gnt_ie02,
    output logic       o_wait_ie01,
    output logic       o_wait_ie02,
    output logic [2:0] o_fun_ativa,
    output logic [1:0] o_perf_dono,
    output logic       o_err
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_GRANT = 2'd2} state_t;

    localparam logic [CNT_W-1:0] LOAD = CNT_W'(HOLD_CYCLES - 1);

    state_t           r_st01, r_st02, w_st01_nx, w_st02_nx;
    logic [CNT_W-1:0] r_cnt01, r_cnt02, w_cnt01_nx, w_cnt02_nx;
    logic [2:0]       r_fun01, r_fun02, w_fun01_nx, w_fun02_nx;
    logic [1:0]       r_perf01, r_perf02, w_perf01_nx, w_perf02_nx;
    logic [1:0]       r_perf_dono, w_perf_dono_nx;
    logic             r_req_q01, r_req_q02;
    logic             r_last_winner, w_last_winner_nx;  // 0 = IE01, 1 = IE02
    logic             r_err, w_err_nx;
    logic             w_enter01, w_enter02;

    function automatic logic f_onehot(input logic [2:0] f);
        return (f == 3'b001) || (f == 3'b010) || (f == 3'b100);
    endfunction

    logic w_new01, w_new02, w_valid01, w_valid02, w_go01, w_go02;
    logic w_busy01, w_busy02, w_held01, w_held02, w_tie, w_win01;

    assign w_new01   = i_req_ie01 & ~r_req_q01;
    assign w_new02   = i_req_ie02 & ~r_req_q02;
    assign w_valid01 = f_onehot(i_fun_ie01) && (i_perf_ie01 != 2'd0);
    assign w_valid02 = f_onehot(i_fun_ie02) && (i_perf_ie02 != 2'd0);
    assign w_go01    = w_new01 && w_valid01 && (r_st01 == S_IDLE);
    assign w_go02    = w_new02 && w_valid02 && (r_st02 == S_IDLE);

    // A holder in its last cycle (counter at 0) no longer blocks the function.
    assign w_busy01 = (r_st02 == S_GRANT) && (r_fun02 == i_fun_ie01) && (r_cnt02 != '0);
    assign w_busy02 = (r_st01 == S_GRANT) && (r_fun01 == i_fun_ie02) && (r_cnt01 != '0);
    assign w_held01 = (r_st02 == S_GRANT) && (r_fun02 == r_fun01) && (r_cnt02 != '0);
    assign w_held02 = (r_st01 == S_GRANT) && (r_fun01 == r_fun02) && (r_cnt01 != '0);

    // Simultaneous valid requests for the same function: profile first, then alternate.
    assign w_tie   = w_go01 && w_go02 && (i_fun_ie01 == i_fun_ie02);
    assign w_win01 = (i_perf_ie01 > i_perf_ie02) ||
                     ((i_perf_ie01 == i_perf_ie02) && r_last_winner);

    always_comb begin
        w_st01_nx        = r_st01;
        w_st02_nx        = r_st02;
        w_cnt01_nx       = r_cnt01;
        w_cnt02_nx       = r_cnt02;
        w_fun01_nx       = r_fun01;
        w_fun02_nx       = r_fun02;
        w_perf01_nx      = r_perf01;
        w_perf02_nx      = r_perf02;
        w_perf_dono_nx   = r_perf_dono;
        w_last_winner_nx = r_last_winner;
        w_err_nx         = 1'b0;
        w_enter01        = 1'b0;
        w_enter02        = 1'b0;

        case (r_st01)
            S_IDLE: begin
                if (w_go01) begin
                    w_fun01_nx  = i_fun_ie01;
                    w_perf01_nx = i_perf_ie01;
                    if (w_tie) begin
                        if (w_win01) w_enter01 = 1'b1;
                        else         w_st01_nx = S_WAIT;
                    end else if (w_busy01) begin
                        w_st01_nx = S_WAIT;
                    end else begin
                        w_enter01 = 1'b1;
                    end
                end else if (w_new01 && !w_valid01) begin
                    w_err_nx = 1'b1;
                end
            end
            S_WAIT:  if (!w_held01) w_enter01 = 1'b1;
            S_GRANT: begin
                if (r_cnt01 == '0) w_st01_nx  = S_IDLE;
                else               w_cnt01_nx = r_cnt01 - CNT_W'(1);
            end
            default: w_st01_nx = S_IDLE;
        endcase

        case (r_st02)
            S_IDLE: begin
                if (w_go02) begin
                    w_fun02_nx  = i_fun_ie02;
                    w_perf02_nx = i_perf_ie02;
                    if (w_tie) begin
                        if (!w_win01) w_enter02 = 1'b1;
                        else          w_st02_nx = S_WAIT;
                    end else if (w_busy02) begin
                        w_st02_nx = S_WAIT;
                    end else begin
                        w_enter02 = 1'b1;
                    end
                end else if (w_new02 && !w_valid02) begin
                    w_err_nx = 1'b1;
                end
            end
            S_WAIT:  if (!w_held02) w_enter02 = 1'b1;
            S_GRANT: begin
                if (r_cnt02 == '0) w_st02_nx  = S_IDLE;
                else               w_cnt02_nx = r_cnt02 - CNT_W'(1);
            end
            default: w_st02_nx = S_IDLE;
        endcase

        if (w_enter01) begin
            w_st01_nx  = S_GRANT;
            w_cnt01_nx = LOAD;
        end
        if (w_enter02) begin
            w_st02_nx  = S_GRANT;
            w_cnt02_nx = LOAD;
        end

        // Joint entry flips the winner (the station a tie would have favoured).
        if (w_enter01 && w_enter02) w_last_winner_nx = ~r_last_winner;
        else if (w_enter01)         w_last_winner_nx = 1'b0;
        else if (w_enter02)         w_last_winner_nx = 1'b1;

        if (w_enter01)      w_perf_dono_nx = w_perf01_nx;
        else if (w_enter02) w_perf_dono_nx = w_perf02_nx;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_st01        <= S_IDLE;
            r_st02        <= S_IDLE;
            r_cnt01       <= '0;
            r_cnt02       <= '0;
            r_fun01       <= 3'b000;
            r_fun02       <= 3'b000;
            r_perf01      <= 2'd0;
            r_perf02      <= 2'd0;
            r_perf_dono   <= 2'd0;
            r_req_q01     <= 1'b1;
            r_req_q02     <= 1'b1;
            r_last_winner <= 1'b1;
            r_err         <= 1'b0;
        end else begin
            r_st01        <= w_st01_nx;
            r_st02        <= w_st02_nx;
            r_cnt01       <= w_cnt01_nx;
            r_cnt02       <= w_cnt02_nx;
            r_fun01       <= w_fun01_nx;
            r_fun02       <= w_fun02_nx;
            r_perf01      <= w_perf01_nx;
            r_perf02      <= w_perf02_nx;
            r_perf_dono   <= w_perf_dono_nx;
            r_req_q01     <= i_req_ie01;
            r_req_q02     <= i_req_ie02;
            r_last_winner <= w_last_winner_nx;
            r_err         <= w_err_nx;
        end
    end

    assign o_gnt_ie01  = (r_st01 == S_GRANT);
    assign o_gnt_ie02  = (r_st02 == S_GRANT);
    assign o_wait_ie01 = (r_st01 == S_WAIT);
    assign o_wait_ie02 = (r_st02 == S_WAIT);
    assign o_fun_ativa = (o_gnt_ie01 ? r_fun01 : 3'b000) | (o_gnt_ie02 ? r_fun02 : 3'b000);
    assign o_perf_dono = r_perf_dono;
    assign o_err       = r_err;
endmodule

// File: tb/tb_arbitro_funcoes.sv
// tb/tb_arbitro_funcoes.sv - scoreboard bench for arbitro_funcoes with an ownership-timeline reference model
module tb_arbitro_funcoes;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       req[2];
    logic [2:0] fun[2];
    logic [1:0] perf[2];
    logic       gnt01, gnt02, wt01, wt02, err;
    logic [2:0] fa;
    logic [1:0] dono;

    always #5 clk = ~clk;

    arbitro_funcoes #(.HOLD_CYCLES(H), .CNT_W(3)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_ie01(req[0]), .i_req_ie02(req[1]),
        .i_fun_ie01(fun[0]), .i_fun_ie02(fun[1]),
        .i_perf_ie01(perf[0]), .i_perf_ie02(perf[1]),
        .o_gnt_ie01(gnt01), .o_gnt_ie02(gnt02),
        .o_wait_ie01(wt01), .o_wait_ie02(wt02),
        .o_fun_ativa(fa), .o_perf_dono(dono), .o_err(err)
    );

    typedef struct packed {
        logic [1:0] gnt;
        logic [1:0] wt;
        logic [2:0] fa;
        logic [1:0] dono;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each station is idle, waiting, or holding until an absolute end edge.
    localparam int IDLE = 0, WAITING = 1, HOLDING = 2;
    int         m_mode[2];
    int         m_end[2];
    logic [2:0] m_fun[2];
    logic [1:0] m_perf[2];
    logic       m_prev[2];
    int         m_lw;
    logic [1:0] m_dono;
    logic       m_err;
    int         cyc = 0;

    function automatic void model_reset();
        for (int s = 0; s < 2; s++) begin
            m_mode[s] = IDLE; m_end[s] = 0; m_fun[s] = 0; m_perf[s] = 0; m_prev[s] = 1'b1;
        end
        m_lw = 1; m_dono = 0; m_err = 0;
    endfunction

    // Does station o block function f on the edge numbered n?
    function automatic bit blocks(input int o, input logic [2:0] f, input int n);
        return (m_mode[o] == HOLDING) && (m_fun[o] == f) && (m_end[o] != n);
    endfunction

    function automatic void model_step();
        int n = cyc + 1;
        int nmode[2];
        int nend[2];
        logic [2:0] nfun[2];
        logic [1:0] nperf[2];
        bit enter[2], nw[2], ok[2];
        int win;
        for (int s = 0; s < 2; s++) begin
            nw[s] = req[s] && !m_prev[s];
            ok[s] = ($countones(fun[s]) == 1) && (perf[s] != 0);
            nmode[s] = m_mode[s]; nend[s] = m_end[s]; nfun[s] = m_fun[s]; nperf[s] = m_perf[s];
            enter[s] = 0;
        end
        win = (perf[0] > perf[1]) ? 0 : (perf[1] > perf[0]) ? 1 : 1 - m_lw;
        m_err = 0;
        for (int s = 0; s < 2; s++) begin
            int o = 1 - s;
            if (m_mode[s] == HOLDING) begin
                if (m_end[s] == n) nmode[s] = IDLE;
            end else if (m_mode[s] == WAITING) begin
                if (!blocks(o, m_fun[s], n)) enter[s] = 1;
            end else if (nw[s] && ok[s]) begin
                nfun[s] = fun[s]; nperf[s] = perf[s];
                if (m_mode[o] == IDLE && nw[o] && ok[o] && fun[o] == fun[s]) begin
                    if (win == s) enter[s] = 1; else nmode[s] = WAITING;
                end else if (blocks(o, fun[s], n)) nmode[s] = WAITING;
                else enter[s] = 1;
            end else if (nw[s]) m_err = 1;
        end
        for (int s = 0; s < 2; s++)
            if (enter[s]) begin nmode[s] = HOLDING; nend[s] = n + H; end
        if (enter[0] && enter[1]) m_lw = 1 - m_lw;
        else if (enter[0])        m_lw = 0;
        else if (enter[1])        m_lw = 1;
        if (enter[0])      m_dono = nperf[0];
        else if (enter[1]) m_dono = nperf[1];
        for (int s = 0; s < 2; s++) begin
            m_mode[s] = nmode[s]; m_end[s] = nend[s]; m_fun[s] = nfun[s]; m_perf[s] = nperf[s];
            m_prev[s] = req[s];
        end
        cyc = n;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.gnt  = {m_mode[1] == HOLDING, m_mode[0] == HOLDING};
        e.wt   = {m_mode[1] == WAITING, m_mode[0] == WAITING};
        e.fa   = (m_mode[0] == HOLDING ? m_fun[0] : 3'b000) | (m_mode[1] == HOLDING ? m_fun[1] : 3'b000);
        e.dono = m_dono;
        e.err  = m_err;
        return e;
    endfunction

    task automatic step(input logic r, input logic q0, input logic [2:0] f0, input logic [1:0] p0,
                        input logic q1, input logic [2:0] f1, input logic [1:0] p1);
        rst = r; req[0] = q0; fun[0] = f0; perf[0] = p0; req[1] = q1; fun[1] = f1; perf[1] = p1;
        if (r) model_reset(); else model_step();
        @(posedge clk); #1;
        sb.push_back(model_out());
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 3'b000, 2'd0, 0, 3'b000, 2'd0);
    endtask

    // Reset asserted between clock edges must clear outputs without waiting for a clock.
    task automatic async_reset(input int n);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst_async_outputs", {gnt02, gnt01, wt02, wt01, err, fa}, 8'h00);
        chk("rst_async_dono", {6'b0, dono}, 8'h00);
        repeat (n) step(1, req[0], fun[0], perf[0], req[1], fun[1], perf[1]);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("gnt",       {6'b0, gnt02, gnt01}, {6'b0, e.gnt});
                chk("wait",      {6'b0, wt02, wt01},   {6'b0, e.wt});
                chk("fun_ativa", {5'b0, fa},           {5'b0, e.fa});
                chk("perf_dono", {6'b0, dono},         {6'b0, e.dono});
                chk("err",       {7'b0, err},          {7'b0, e.err});
            end
        end
    end

    function automatic logic rnd_req(input int s);
        return ($urandom_range(0, 2) == 0) ? ~req[s] : req[s];
    endfunction

    function automatic logic [2:0] rnd_fun();
        logic [2:0] tbl[9] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b011, 3'b000, 3'b110};
        return tbl[$urandom_range(0, 8)];
    endfunction

    initial begin
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin req[s] = 0; fun[s] = 0; perf[s] = 0; end
        step(1, 0, 3'b000, 2'd0, 0, 3'b000, 2'd0);
        step(1, 0, 3'b000, 2'd0, 0, 3'b000, 2'd0);
        idle(2);
        // single grant
        step(0, 1, 3'b001, 2'd2, 0, 3'b000, 2'd0); idle(7);
        // profile conflict and handover
        step(0, 1, 3'b010, 2'd1, 1, 3'b010, 2'd3); idle(10);
        // equal-profile ties from a fresh reset
        async_reset(1); idle(2);
        step(0, 1, 3'b100, 2'd2, 1, 3'b100, 2'd2); idle(10);
        step(0, 1, 3'b100, 2'd2, 1, 3'b100, 2'd2); idle(10);
        // different functions together
        step(0, 1, 3'b001, 2'd1, 1, 3'b100, 2'd2); idle(6);
        // invalid requests, then request held across reset release
        step(0, 1, 3'b011, 2'd2, 1, 3'b001, 2'd0); idle(2);
        step(0, 0, 3'b000, 2'd0, 1, 3'b000, 2'd3); idle(2);
        step(0, 1, 3'b010, 2'd3, 0, 3'b000, 2'd0);
        step(0, 1, 3'b010, 2'd3, 0, 3'b000, 2'd0);
        async_reset(2);
        repeat (3) step(0, 1, 3'b010, 2'd3, 0, 3'b000, 2'd0);
        step(0, 0, 3'b010, 2'd3, 0, 3'b000, 2'd0);
        step(0, 1, 3'b010, 2'd3, 0, 3'b000, 2'd0); idle(6);
        // reset while one station holds and the other waits
        step(0, 1, 3'b010, 2'd2, 0, 3'b000, 2'd0);
        step(0, 1, 3'b010, 2'd2, 1, 3'b010, 2'd3);
        step(0, 0, 3'b000, 2'd0, 0, 3'b000, 2'd0);
        async_reset(1); idle(4);
        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) async_reset($urandom_range(1, 2));
            else step(0, rnd_req(0), rnd_fun(), 2'($urandom_range(0, 3)),
                      rnd_req(1), rnd_fun(), 2'($urandom_range(0, 3)));
        end
        idle(2);
        @(negedge clk); #1;
        chk("sb_drain", 8'(sb.size()), 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
